// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: one memory transaction at a time over a registered
// request/response handshake, with strobes, load extension and timeout.
module ysyx_22040125_lsu #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic [7:0]  mem_wmask,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_data,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TERM =
      CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

   state_t        state_q, state_d;
   logic          st_q, uns_q, err_q;
   logic [1:0]    size_q;
   logic [2:0]    off_q;
   logic [28:0]   addr_q;
   logic [63:0]   wdata_q, data_q;
   logic [7:0]    wmask_q, wmask_d;
   logic [CW-1:0] cnt_q;
   logic          mis, timeout;
   logic [63:0]   sh, ld;

   always_comb begin
      mis = 1'b0;
      unique case (req_size)
         2'd0:    mis = 1'b0;
         2'd1:    mis = req_addr[0];
         2'd2:    mis = |req_addr[1:0];
         default: mis = |req_addr[2:0];
      endcase
   end

   always_comb begin
      wmask_d = 8'h00;
      if (req_store) begin
         unique case (req_size)
            2'd0:    wmask_d = 8'h01 << req_addr[2:0];
            2'd1:    wmask_d = 8'h03 << req_addr[2:0];
            2'd2:    wmask_d = 8'h0F << req_addr[2:0];
            default: wmask_d = 8'hFF;
         endcase
      end
   end

   // extension always uses the fields latched at acceptance
   always_comb begin
      sh = mem_rdata >> {off_q, 3'b000};
      ld = sh;
      unique case (size_q)
         2'd0:    ld = uns_q ? {56'd0, sh[7:0]}
                             : {{56{sh[7]}}, sh[7:0]};
         2'd1:    ld = uns_q ? {48'd0, sh[15:0]}
                             : {{48{sh[15]}}, sh[15:0]};
         2'd2:    ld = uns_q ? {32'd0, sh[31:0]}
                             : {{32{sh[31]}}, sh[31:0]};
         default: ld = sh;
      endcase
   end

   assign timeout = TO_EN && (cnt_q == TERM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (req_valid) state_d = mis ? RESP : REQ;
         REQ:  if (mem_req_ready) state_d = WAIT;
         WAIT: if (mem_rsp_valid || timeout) state_d = RESP;
         RESP: if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'd0;
         off_q   <= 3'd0;
         addr_q  <= 29'd0;
         wdata_q <= 64'd0;
         wmask_q <= 8'd0;
         cnt_q   <= '0;
         data_q  <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == IDLE && req_valid) begin
            st_q    <= req_store;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            off_q   <= req_addr[2:0];
            addr_q  <= req_addr[31:3];
            wdata_q <= req_wdata;
            wmask_q <= wmask_d;
            if (mis) begin
               data_q <= 64'd0;
               err_q  <= 1'b1;
            end
         end
         if (state_q == REQ && mem_req_ready) cnt_q <= '0;
         // a response on the terminal count takes priority over the error
         if (state_q == WAIT) begin
            if (mem_rsp_valid) begin
               data_q <= st_q ? 64'd0 : ld;
               err_q  <= 1'b0;
            end else if (timeout) begin
               data_q <= 64'd0;
               err_q  <= 1'b1;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end
      end
   end

   always_comb begin
      req_ready     = (state_q == IDLE);
      mem_req_valid = (state_q == REQ);
      rsp_valid     = (state_q == RESP);
      mem_wen       = st_q;
      mem_addr      = {addr_q, 3'b000};
      mem_wdata     = wdata_q;
      mem_wmask     = wmask_q;
      rsp_data      = data_q;
      rsp_err       = err_q;
   end

endmodule

// File: tb/tb_ysyx_22040125_lsu.sv
// Bench for ysyx_22040125_lsu: directed transactions with a response
// scoreboard, backpressure, timeout and asynchronous reset cases.
module tb_ysyx_22040125_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_wmask;
   logic        mem_rsp_valid = 1'b0;
   logic [63:0] mem_rdata = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_data;
   logic        rsp_err;

   localparam int TMO = 4;

   ysyx_22040125_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   n_run = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] act,
                      input logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   exp_t e;
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
         end
      end
   end

   // rsp_dly < 0 means the memory never answers
   task automatic txn(input logic st, input logic [1:0] sz,
                      input logic un, input logic [31:0] a,
                      input logic [63:0] wd, input logic [63:0] rd,
                      input logic [63:0] ed, input logic ee,
                      input logic mis, input logic [7:0] msk,
                      input int ack_dly, input int rsp_dly,
                      input int hold);
      logic [31:0] ma;
      int w;
      ma = {a[31:3], 3'b000};
      @(posedge clk); #1;
      chk("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_store = st;
      req_size = sz;
      req_unsigned = un;
      req_addr = a;
      req_wdata = wd;
      sb.push_back('{ed, ee});
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr = $urandom;
      req_wdata = {$urandom, $urandom};
      req_store = ~st;
      if (mis) begin
         @(negedge clk);
         chk("mis_noreq", 64'(mem_req_valid), 64'd0);
         chk("mis_rsp_lat", 64'(rsp_valid), 64'd1);
      end else begin
         for (int i = 0; i <= ack_dly; i++) begin
            mem_req_ready = (i == ack_dly);
            @(negedge clk);
            chk("mem_req_valid", 64'(mem_req_valid), 64'd1);
            chk("mem_addr", 64'(mem_addr), 64'(ma));
            chk("mem_wen", 64'(mem_wen), 64'(st));
            chk("mem_wmask", 64'(mem_wmask), 64'(msk));
            chk("mem_wdata", mem_wdata, wd);
            chk("req_ready_busy", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
         end
         mem_req_ready = 1'b0;
         if (rsp_dly >= 0) begin
            repeat (rsp_dly) @(posedge clk);
            #1;
            mem_rsp_valid = 1'b1;
            mem_rdata = rd;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            chk("rsp_lat", 64'(rsp_valid), 64'd1);
         end else begin
            w = 0;
            @(negedge clk);
            while (!rsp_valid && w < 20) begin
               @(negedge clk);
               w++;
            end
            chk("timeout_lat", 64'(w), 64'(TMO));
         end
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_valid", 64'(rsp_valid), 64'd1);
         chk("hold_data", rsp_data, ed);
         chk("hold_err", 64'(rsp_err), 64'(ee));
         chk("hold_req_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #1;
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      @(negedge clk);
      chk("back_idle", 64'(req_ready), 64'd1);
      chk("rsp_drop", 64'(rsp_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // LB signed
      txn(0, 2'd0, 0, 32'h8000_0005, 64'h1111_2222_3333_4444,
          64'h0000_80FF_0000_0000, 64'hFFFF_FFFF_FFFF_FF80, 0,
          0, 8'h00, 0, 0, 0);
      // LWU / LW
      txn(0, 2'd2, 1, 32'h8000_0004, 64'd0,
          64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321, 0,
          0, 8'h00, 0, 0, 0);
      txn(0, 2'd2, 0, 32'h8000_0004, 64'd0,
          64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321, 0,
          0, 8'h00, 0, 1, 0);
      // SH with request and response backpressure
      txn(1, 2'd1, 0, 32'h8000_0006, 64'hBEEF_BEEF_BEEF_BEEF,
          64'hDEAD_DEAD_DEAD_DEAD, 64'd0, 0,
          0, 8'hC0, 3, 1, 3);
      // misaligned word, half, double
      txn(0, 2'd2, 0, 32'h8000_0002, 64'd0, 64'd0, 64'd0, 1,
          1, 8'h00, 0, 0, 2);
      txn(1, 2'd1, 0, 32'h8000_0001, 64'd5, 64'd0, 64'd0, 1,
          1, 8'h00, 0, 0, 0);
      txn(0, 2'd3, 0, 32'h8000_0004, 64'd0, 64'd0, 64'd0, 1,
          1, 8'h00, 0, 0, 0);
      // LD ignores unsigned
      txn(0, 2'd3, 1, 32'h8000_0008, 64'd0,
          64'hF123_4567_89AB_CDEF, 64'hF123_4567_89AB_CDEF, 0,
          0, 8'h00, 0, 0, 0);
      // LH / LHU
      txn(0, 2'd1, 0, 32'h8000_0002, 64'd0,
          64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001, 0,
          0, 8'h00, 1, 0, 0);
      txn(0, 2'd1, 1, 32'h8000_0002, 64'd0,
          64'h0000_0000_8001_0000, 64'h0000_0000_0000_8001, 0,
          0, 8'h00, 0, 2, 0);
      // SB, SW, SD strobes
      txn(1, 2'd0, 0, 32'h8000_0003, 64'h5A5A_5A5A_5A5A_5A5A,
          64'd0, 64'd0, 0, 0, 8'h08, 0, 0, 0);
      txn(1, 2'd2, 0, 32'h8000_0004, 64'h1234_5678_1234_5678,
          64'd0, 64'd0, 0, 0, 8'hF0, 0, 0, 0);
      txn(1, 2'd3, 0, 32'h8000_0010, 64'h0102_0304_0506_0708,
          64'd0, 64'd0, 0, 0, 8'hFF, 2, 0, 0);
      // response on the terminal count wins over timeout
      txn(0, 2'd0, 1, 32'h8000_0007, 64'd0,
          64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB, 0,
          0, 8'h00, 0, TMO - 1, 0);
      // timeout
      txn(0, 2'd2, 0, 32'h8000_0000, 64'd0, 64'd0, 64'd0, 1,
          0, 8'h00, 0, -1, 1);

      // late response in IDLE is dropped
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1;
      mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      chk("late_idle_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("late_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("late_mem_req", 64'(mem_req_valid), 64'd0);

      // reset while in WAIT
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_store = 1'b1;
      req_size = 2'd3;
      req_addr = 32'h8000_0040;
      req_wdata = 64'hCAFE_CAFE_CAFE_CAFE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req_ready", 64'(req_ready), 64'd1);
      chk("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      chk("arst_mem_wen", 64'(mem_wen), 64'd0);
      chk("arst_mem_addr", 64'(mem_addr), 64'd0);
      chk("arst_mem_wdata", mem_wdata, 64'd0);
      chk("arst_mem_wmask", 64'(mem_wmask), 64'd0);
      chk("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("arst_rsp_data", rsp_data, 64'd0);
      chk("arst_rsp_err", 64'(rsp_err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_rsp", 64'(rsp_valid), 64'd0);

      // normal operation after reset
      txn(0, 2'd0, 0, 32'h8000_0001, 64'd0,
          64'h0000_0000_0000_7F00, 64'h0000_0000_0000_007F, 0,
          0, 8'h00, 0, 0, 0);

      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
